s2p_frame_deser: RTL and testbench
==================================

// Module: s2p_frame_deser
// PURPOSE
//  Parametrised serial-to-parallel deserialiser: collects DEPTH consecutive WIDTH-bit words from a
//  valid/ready stream into one DEPTH*WIDTH-bit frame. Presents the frame on a registered,
//  handshaked output. Adds flow control, frame counting, word-order mode and partial-frame flush.
//  Sits between a serial word source (ADC/link RX) and parallel frame consumers.
// PARAMETERS
//  WIDTH   16  bits per input word
//  DEPTH   8   words per frame (>=2)
//  CNT_W   $clog2(DEPTH+1)  width of fill counter (derived, do not override)
// PORTS
//  clk         in   1            rising-edge clock
//  rst         in   1            asynchronous, active-high reset
//  in_data     in   WIDTH        serial word
//  in_valid    in   1            in_data valid
//  in_ready    out  1            block accepts word this cycle
//  flush       in   1            sync discard of partial frame
//  msb_first   in   1            1: first word lands in top slot; 0: in slot 0
//  out_data    out  DEPTH*WIDTH  assembled frame
//  out_valid   out  1            frame valid
//  out_ready   in   1            consumer accepts frame
//  fill        out  CNT_W        words held in partial frame (0..DEPTH-1)
//  frame_cnt   out  16           frames delivered, wraps 0xFFFF->0
// BEHAVIOUR
//  Reset (async, rst=1): shift line, out_data, fill, frame_cnt = 0; out_valid=0; in_ready=0 while rst high.
//  Accept = in_valid & in_ready. On accept with fill<DEPTH-1: word shifts into shift line, fill+1.
//  On accept with fill==DEPTH-1 (frame-completing word): shift contents + new word load out_data
//    same edge; out_valid=1; fill=0; frame_cnt+1. Latency: last word in -> out_valid next cycle.
//  in_ready = ~rst & ~flush & ((fill!=DEPTH-1) | ~out_valid | out_ready).
//    The partial frame keeps filling while the previous frame is held; only the completing word stalls.
//  Output handshake: out_valid & out_ready retires the frame; out_valid drops next cycle unless a
//    completing word is accepted the same cycle (back-to-back: out_valid stays 1, out_data = new frame).
//  out_data stable while out_valid & ~out_ready.
//  Word order: msb_first=1 -> first word of frame at out_data[DEPTH*WIDTH-1 -: WIDTH], last at [WIDTH-1:0];
//    msb_first=0 -> mirrored. msb_first is sampled per word; changing it mid-frame is undefined, so
//    change only when fill==0.
//  flush=1: fill=0 and shift line cleared next edge; in_ready=0 that cycle (the presented word is
//    not consumed); held out_data/out_valid unaffected; frame_cnt unchanged.
//  No overflow possible: source is stalled via in_ready. frame_cnt wraps silently.
//  Reset mid-frame or mid-handshake: all state drops to reset values immediately; the frame is lost.
// STRUCTURE
//  Package s2p_pkg: localparam MSB_FIRST=1'b1 / LSB_FIRST=1'b0; frame_cnt width constant FCNT_W=16.
//  Sub-module s2p_word_reg: WIDTH-bit D flip-flop with clock enable, sync clear, async rst;
//    instantiated DEPTH-1 times via generate for the shift line (plus one for the output frame slice).
//  Top holds fill counter, in/out handshake logic, order mux, frame_cnt.
// TESTING
//  1 Reset: rst pulse mid-clock -> out_valid=0, fill=0, out_data=0, in_ready=0 during rst, 1 after.
//  2 Default params, msb_first=1, feed 0x0001..0x0008 with out_ready=1 ->
//    out_data=0x0001_0002_..._0008, out_valid one cycle, frame_cnt=1.
//  3 Same words, msb_first=0 -> out_data=0x0008_0007_..._0001.
//  4 out_ready=0, stream 16 words continuously -> first frame held stable; in_ready=0 only on
//    word 16 (fill=7); raise out_ready -> word 16 accepted, second frame 0x0009..0x0010 appears
//    next cycle, out_valid never drops.
//  5 Feed 3 words, assert flush with in_valid=1, word 0xBEEF -> fill=0, 0xBEEF not taken;
//    next 8 words form a clean frame.
//  6 WIDTH=8, DEPTH=3: 65536 frames -> frame_cnt wraps to 0; rst during fill=2 -> no frame emitted.

Source files
------------

// File: rtl/s2p_pkg.sv
// Shared constants for the serial-to-parallel frame deserialiser.
package s2p_pkg;

    localparam logic MSB_FIRST = 1'b1;
    localparam logic LSB_FIRST = 1'b0;
    localparam int   FCNT_W    = 16;

endpackage

// File: rtl/s2p_word_reg.sv
// One word of storage: clock enable, synchronous clear, asynchronous reset.
module s2p_word_reg #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Clear wins over load so a flush can never be overridden by a stray enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end else begin
            q <= q;
        end
    end

endmodule

// File: rtl/s2p_frame_deser.sv
// Collects DEPTH words from a valid/ready stream into one registered, handshaked frame.
module s2p_frame_deser
    import s2p_pkg::*;
#(
    parameter  int WIDTH = 16,
    parameter  int DEPTH = 8,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH-1:0]       in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   flush,
    input  logic                   msb_first,
    output logic [DEPTH*WIDTH-1:0] out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [CNT_W-1:0]       fill,
    output logic [FCNT_W-1:0]      frame_cnt
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEPTH - 1);

    logic             accept;
    logic             complete;
    logic [WIDTH-1:0] shift_q [DEPTH-1];
    logic [WIDTH-1:0] arrival [DEPTH];
    logic [WIDTH-1:0] slot_d  [DEPTH];
    logic [WIDTH-1:0] slot_q  [DEPTH];

    // Only the completing word waits on the consumer; partial words keep flowing.
    assign in_ready = ~rst & ~flush & ((fill != LAST) | ~out_valid | out_ready);
    assign accept   = in_valid & in_ready;
    assign complete = accept & (fill == LAST);

    // shift_q[0] is the newest held word, shift_q[DEPTH-2] the oldest.
    for (genvar k = 0; k < DEPTH - 1; k++) begin : g_shift
        if (k == 0) begin : g_head
            s2p_word_reg #(.WIDTH(WIDTH)) u_reg (
                .clk (clk),
                .rst (rst),
                .en  (accept & ~complete),
                .clr (flush),
                .d   (in_data),
                .q   (shift_q[k])
            );
        end else begin : g_tail
            s2p_word_reg #(.WIDTH(WIDTH)) u_reg (
                .clk (clk),
                .rst (rst),
                .en  (accept & ~complete),
                .clr (flush),
                .d   (shift_q[k-1]),
                .q   (shift_q[k])
            );
        end
    end

    // arrival[i] is the i-th word of the frame in stream order; the live word is last.
    assign arrival[DEPTH-1] = in_data;
    for (genvar i = 0; i < DEPTH - 1; i++) begin : g_arrival
        assign arrival[i] = shift_q[DEPTH-2-i];
    end

    // Order mux: map stream order onto output slots.
    always_comb begin
        for (int j = 0; j < DEPTH; j++) begin
            slot_d[j] = '0;
            case (msb_first)
                MSB_FIRST: slot_d[j] = arrival[DEPTH-1-j];
                LSB_FIRST: slot_d[j] = arrival[j];
                default:   slot_d[j] = '0;
            endcase
        end
    end

    for (genvar j = 0; j < DEPTH; j++) begin : g_out
        s2p_word_reg #(.WIDTH(WIDTH)) u_reg (
            .clk (clk),
            .rst (rst),
            .en  (complete),
            .clr (1'b0),
            .d   (slot_d[j]),
            .q   (slot_q[j])
        );
    end

    // Pack the output slot registers onto the frame bus.
    always_comb begin
        out_data = '0;
        for (int j = 0; j < DEPTH; j++) begin
            out_data[j*WIDTH +: WIDTH] = slot_q[j];
        end
    end

    // Fill level, output valid and delivered-frame count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill      <= '0;
            out_valid <= 1'b0;
            frame_cnt <= '0;
        end else begin
            if (flush || complete) begin
                fill <= '0;
            end else if (accept) begin
                fill <= fill + CNT_W'(1);
            end else begin
                fill <= fill;
            end

            if (complete) begin
                out_valid <= 1'b1;
                frame_cnt <= frame_cnt + FCNT_W'(1);
            end else if (out_ready) begin
                out_valid <= 1'b0;
                frame_cnt <= frame_cnt;
            end else begin
                out_valid <= out_valid;
                frame_cnt <= frame_cnt;
            end
        end
    end

endmodule

// File: tb/tb_s2p_frame_deser.sv
// Bench for s2p_frame_deser: queue-based frame model checked every cycle plus directed literals.
module tb_s2p_frame_deser;

    localparam int D = 8;
    localparam int W = 16;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [W-1:0]   in_data = '0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic           flush = 1'b0;
    logic           msb_first = 1'b1;
    logic [D*W-1:0] out_data;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic [3:0]     fill;
    logic [15:0]    frame_cnt;

    logic           b_rst = 1'b1;
    logic [7:0]     b_in_data = '0;
    logic           b_in_valid = 1'b0;
    logic           b_in_ready;
    logic           b_flush = 1'b0;
    logic           b_msb_first = 1'b1;
    logic [23:0]    b_out_data;
    logic           b_out_valid;
    logic           b_out_ready = 1'b1;
    logic [1:0]     b_fill;
    logic [15:0]    b_frame_cnt;

    int ntests = 0;
    int nfail  = 0;

    always #5 clk = ~clk;

    s2p_frame_deser #(.WIDTH(W), .DEPTH(D)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .flush(flush), .msb_first(msb_first), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .fill(fill), .frame_cnt(frame_cnt)
    );

    s2p_frame_deser #(.WIDTH(8), .DEPTH(3)) dut_b (
        .clk(clk), .rst(b_rst), .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .flush(b_flush), .msb_first(b_msb_first), .out_data(b_out_data), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .fill(b_fill), .frame_cnt(b_frame_cnt)
    );

    // Reference model: words queued in arrival order, frame built when DEPTH are held.
    logic [W-1:0]   m_q[$];
    logic           m_ov  = 1'b0;
    logic [D*W-1:0] m_od  = '0;
    logic [15:0]    m_fc  = '0;
    logic           m_ir;
    logic           m_acc;
    logic           m_done;

    always begin
        @(negedge clk);
        #2;
        if (rst) begin
            m_q.delete();
            m_ov = 1'b0;
            m_od = '0;
            m_fc = '0;
        end
        m_ir = !rst && !flush && (m_q.size() != D - 1 || !m_ov || out_ready);
        ntests++;
        if (in_ready !== m_ir || out_valid !== m_ov || fill !== 4'(m_q.size())
            || frame_cnt !== m_fc || out_data !== m_od) begin
            nfail++;
            $display("FAIL model t=%0t ready %b want %b valid %b want %b fill %0d want %0d cnt %0d want %0d data %h want %h",
                     $time, in_ready, m_ir, out_valid, m_ov, fill, m_q.size(), frame_cnt, m_fc, out_data, m_od);
        end
        if (!rst) begin
            m_acc  = in_valid && m_ir;
            m_done = 1'b0;
            if (flush) m_q.delete();
            if (m_acc) begin
                m_q.push_back(in_data);
                if (m_q.size() == D) begin
                    for (int i = 0; i < D; i++) begin
                        if (msb_first) m_od[(D-1-i)*W +: W] = m_q[i];
                        else           m_od[i*W +: W]       = m_q[i];
                    end
                    m_done = 1'b1;
                    m_fc   = m_fc + 16'd1;
                    m_q.delete();
                end
            end
            if (m_done)                  m_ov = 1'b1;
            else if (m_ov && out_ready)  m_ov = 1'b0;
        end
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic put(input logic [W-1:0] w);
        int n = 0;
        @(negedge clk);
        in_data  = w;
        in_valid = 1'b1;
        #1;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!in_ready) check("put_timeout", 128'd0, 128'd1);
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        #3;
    endtask

    task automatic b_put(input logic [7:0] w);
        @(negedge clk);
        b_in_data  = w;
        b_in_valid = 1'b1;
        #1;
        if (!b_in_ready) check("b_stall", 128'd0, 128'd1);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    localparam logic [127:0] FRAME_UP   = 128'h0001_0002_0003_0004_0005_0006_0007_0008;
    localparam logic [127:0] FRAME_DOWN = 128'h0008_0007_0006_0005_0004_0003_0002_0001;
    localparam logic [127:0] FRAME_2ND  = 128'h0009_000a_000b_000c_000d_000e_000f_0010;
    localparam logic [127:0] FRAME_T5   = 128'h0011_0012_0013_0014_0015_0016_0017_0018;

    initial begin
        // 1: reset behaviour
        repeat (2) @(negedge clk);
        #1;
        check("rst_in_ready", 128'(in_ready), 128'd0);
        check("rst_out_valid", 128'(out_valid), 128'd0);
        @(negedge clk);
        rst   = 1'b0;
        b_rst = 1'b0;
        #3;
        check("post_rst_in_ready", 128'(in_ready), 128'd1);
        check("post_rst_fill", 128'(fill), 128'd0);
        check("post_rst_data", out_data, 128'd0);

        // 2: msb_first frame
        msb_first = 1'b1;
        out_ready = 1'b1;
        for (int w = 1; w <= 8; w++) put(16'(w));
        idle();
        check("t2_valid", 128'(out_valid), 128'd1);
        check("t2_data", out_data, FRAME_UP);
        check("t2_cnt", 128'(frame_cnt), 128'd1);
        @(negedge clk);
        #3;
        check("t2_valid_drop", 128'(out_valid), 128'd0);

        // 3: lsb-first frame
        msb_first = 1'b0;
        for (int w = 1; w <= 8; w++) put(16'(w));
        idle();
        check("t3_data", out_data, FRAME_DOWN);
        check("t3_cnt", 128'(frame_cnt), 128'd2);

        // 4: consumer stalled, completing word held off
        @(negedge clk);
        msb_first = 1'b1;
        out_ready = 1'b0;
        for (int w = 1; w <= 15; w++) put(16'(w));
        @(negedge clk);
        in_data  = 16'd16;
        in_valid = 1'b1;
        #1;
        check("t4_stall", 128'(in_ready), 128'd0);
        check("t4_fill", 128'(fill), 128'd7);
        check("t4_held", out_data, FRAME_UP);
        repeat (3) @(negedge clk);
        #1;
        check("t4_held_stable", out_data, FRAME_UP);
        check("t4_held_valid", 128'(out_valid), 128'd1);
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        check("t4_release", 128'(in_ready), 128'd1);
        @(posedge clk);
        idle();
        check("t4_second", out_data, FRAME_2ND);
        check("t4_second_valid", 128'(out_valid), 128'd1);
        check("t4_cnt", 128'(frame_cnt), 128'd4);

        // 5: flush discards partial frame and the presented word
        put(16'h00a1);
        put(16'h00a2);
        put(16'h00a3);
        idle();
        check("t5_fill3", 128'(fill), 128'd3);
        @(negedge clk);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'hbeef;
        #1;
        check("t5_flush_ready", 128'(in_ready), 128'd0);
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        #3;
        check("t5_fill0", 128'(fill), 128'd0);
        for (int w = 17; w <= 24; w++) put(16'(w));
        idle();
        check("t5_frame", out_data, FRAME_T5);
        check("t5_cnt", 128'(frame_cnt), 128'd5);

        // Mixed traffic with random stalls and flushes, checked by the model
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = 16'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 15) == 0);
        end
        @(negedge clk);
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;

        // Reset mid-frame
        put(16'h1111);
        put(16'h2222);
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        #3;
        check("midrst_fill", 128'(fill), 128'd0);
        check("midrst_cnt", 128'(frame_cnt), 128'd0);
        @(negedge clk);
        rst = 1'b0;

        // 6: WIDTH=8, DEPTH=3 frame counter wrap
        for (int k = 0; k < 65535 * 3; k++) b_put(k[7:0]);
        @(negedge clk);
        b_in_valid = 1'b0;
        #3;
        check("t6_cnt_ffff", 128'(b_frame_cnt), 128'hffff);
        check("t6_data_a", 128'(b_out_data), 128'h00fafbfc);
        b_put(8'hfd);
        b_put(8'hfe);
        b_put(8'hff);
        @(negedge clk);
        b_in_valid = 1'b0;
        #3;
        check("t6_cnt_wrap", 128'(b_frame_cnt), 128'd0);
        check("t6_data_b", 128'(b_out_data), 128'h00fdfeff);
        check("t6_valid_b", 128'(b_out_valid), 128'd1);
        b_put(8'h01);
        b_put(8'h02);
        @(negedge clk);
        b_in_valid = 1'b0;
        #3;
        check("t6_fill2", 128'(b_fill), 128'd2);
        @(negedge clk);
        b_rst = 1'b1;
        #3;
        check("t6_rst_valid", 128'(b_out_valid), 128'd0);
        check("t6_rst_fill", 128'(b_fill), 128'd0);
        check("t6_rst_data", 128'(b_out_data), 128'd0);
        check("t6_rst_ready", 128'(b_in_ready), 128'd0);
        @(negedge clk);
        b_rst = 1'b0;
        repeat (3) @(negedge clk);
        #3;
        check("t6_no_frame", 128'(b_out_valid), 128'd0);
        check("t6_cnt_after", 128'(b_frame_cnt), 128'd0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
